imem_boot_loader: RTL and testbench

- Boot sequencer for the instruction memory of riscvboy_top.
- Keeps the core in reset while it accepts a stream of 32-bit instruction words from a host or debug link, and writes them sequentially from address 0 into the instruction RAM write port.
- Holds the core in reset for a fixed number of cycles after the load completes, then releases it.
- Replaces backdoor memory preloading as the supported way to load programs, in simulation and on hardware.

---
 rtl/imem_boot_loader_if.sv | 52 +++++
 rtl/imem_boot_loader.sv | 171 +++++++++++++++++
 tb/tb_imem_boot_loader.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_if
//
// Purpose: bundles everything the boot loader exchanges with the outside
// world: the host word stream, the reload request, the instruction RAM write
// port, the fetch-mux select, the core reset and the loader status.
//
// Signals:
//   ld_valid / ld_ready / ld_data / ld_last : host word stream (valid/ready)
//   reload                                  : single-cycle restart request
//   imem_we / imem_addr / imem_wdata        : instruction RAM write port
//   imem_sel                                : 1 = loader owns RAM, 0 = core
//   core_rst                                : active-high reset to the core
//   busy / done / err_overflow              : loader status
//   words_loaded                            : words written by this load
//
// Modports:
//   master : host/system side (drives the stream and reload)
//   slave  : boot loader side (drives the RAM port, reset and status)
// ---------------------------------------------------------------------------
interface imem_boot_loader_if #(
   parameter int ADDR_W = 11
);

   logic              ld_valid;
   logic              ld_ready;
   logic [31:0]       ld_data;
   logic              ld_last;
   logic              reload;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              imem_sel;
   logic              core_rst;
   logic              busy;
   logic              done;
   logic              err_overflow;
   logic [ADDR_W:0]   words_loaded;

   modport master (
      output ld_valid, ld_data, ld_last, reload,
      input  ld_ready, imem_we, imem_addr, imem_wdata, imem_sel,
             core_rst, busy, done, err_overflow, words_loaded
   );

   modport slave (
      input  ld_valid, ld_data, ld_last, reload,
      output ld_ready, imem_we, imem_addr, imem_wdata, imem_sel,
             core_rst, busy, done, err_overflow, words_loaded
   );

endinterface

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//
// Purpose: boot sequencer for the instruction memory. While loading it holds
// the core in reset and writes a stream of 32-bit host words into the
// instruction RAM from address 0 upward. After the last word it keeps the
// core in reset for RESET_HOLD more cycles, then releases it. A reload
// request from HOLD or RUN starts a fresh load.
//
// Ports:
//   clk_sys : system clock
//   rst     : asynchronous, active-high reset
//   bus     : imem_boot_loader_if.slave (host stream, reload, RAM write
//             port, fetch select, core reset, status)
//
// Parameters:
//   IMEM_DEPTH : instruction RAM depth in 32-bit words
//   ADDR_W     : RAM word-address width, equal to clog2(IMEM_DEPTH)
//   RESET_HOLD : cycles the core stays in reset after the load (1..255)
// ---------------------------------------------------------------------------
module imem_boot_loader #(
   parameter int IMEM_DEPTH = 2048,
   parameter int ADDR_W     = 11,
   parameter int RESET_HOLD = 4
) (
   input  logic              clk_sys,
   input  logic              rst,
   imem_boot_loader_if.slave bus
);

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      HOLD = 2'd1,
      RUN  = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);
   localparam logic [ADDR_W:0]   MAX_WORDS = (ADDR_W + 1)'(IMEM_DEPTH);
   localparam logic [7:0]        HOLD_LAST = 8'(RESET_HOLD - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wordPtr_q, wordPtr_d;
   logic [ADDR_W:0]   wordsLoaded_q, wordsLoaded_d;
   logic [7:0]        holdCnt_q, holdCnt_d;
   logic              imemWe_q, imemWe_d;
   logic [ADDR_W-1:0] imemAddr_q, imemAddr_d;
   logic [31:0]       imemWdata_q, imemWdata_d;
   logic              coreRst_q, coreRst_d;
   logic              errOverflow_q, errOverflow_d;

   logic              ldReady;
   logic              handshake;
   logic              atLastAddr;

   // Ready is a pure decode of the state, gated by reset so the host never
   // sees a transfer accepted while the loader is being reset.
   assign ldReady    = (state_q == LOAD) && !rst;
   assign handshake  = bus.ld_valid && ldReady;
   assign atLastAddr = (wordPtr_q == LAST_ADDR);

   assign bus.ld_ready     = ldReady;
   assign bus.busy         = (state_q != RUN);
   assign bus.done         = (state_q == RUN);
   assign bus.imem_sel     = (state_q == LOAD);
   assign bus.imem_we      = imemWe_q;
   assign bus.imem_addr    = imemAddr_q;
   assign bus.imem_wdata   = imemWdata_q;
   assign bus.core_rst     = coreRst_q;
   assign bus.err_overflow = errOverflow_q;
   assign bus.words_loaded = wordsLoaded_q;

   // State and registered outputs. Reset puts the loader back at the start
   // of a fresh image with the core held in reset and any write abandoned.
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state_q       <= LOAD;
         wordPtr_q     <= '0;
         wordsLoaded_q <= '0;
         holdCnt_q     <= '0;
         imemWe_q      <= 1'b0;
         imemAddr_q    <= '0;
         imemWdata_q   <= '0;
         coreRst_q     <= 1'b1;
         errOverflow_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wordPtr_q     <= wordPtr_d;
         wordsLoaded_q <= wordsLoaded_d;
         holdCnt_q     <= holdCnt_d;
         imemWe_q      <= imemWe_d;
         imemAddr_q    <= imemAddr_d;
         imemWdata_q   <= imemWdata_d;
         coreRst_q     <= coreRst_d;
         errOverflow_q <= errOverflow_d;
      end
   end

   // Next-state logic. Each accepted word becomes a RAM write one cycle
   // later at the pre-increment pointer. The load ends on the flagged last
   // word or when the RAM is full; the pointer never wraps, so words beyond
   // the RAM are simply refused. The final write still lands in the first
   // HOLD cycle, which is safe because the write port is independent of the
   // fetch mux. Reload in HOLD or RUN restarts from address 0 and takes
   // priority over releasing the core; reload in LOAD is ignored.
   always_comb begin
      state_d       = state_q;
      wordPtr_d     = wordPtr_q;
      wordsLoaded_d = wordsLoaded_q;
      holdCnt_d     = holdCnt_q;
      imemWe_d      = 1'b0;
      imemAddr_d    = imemAddr_q;
      imemWdata_d   = imemWdata_q;
      coreRst_d     = coreRst_q;
      errOverflow_d = errOverflow_q;

      unique case (state_q)
         LOAD: begin
            coreRst_d = 1'b1;
            if (handshake) begin
               imemWe_d    = 1'b1;
               imemAddr_d  = wordPtr_q;
               imemWdata_d = bus.ld_data;
               if (!atLastAddr) begin
                  wordPtr_d = wordPtr_q + ADDR_W'(1);
               end
               if (wordsLoaded_q != MAX_WORDS) begin
                  wordsLoaded_d = wordsLoaded_q + (ADDR_W + 1)'(1);
               end
               if (bus.ld_last || atLastAddr) begin
                  state_d   = HOLD;
                  holdCnt_d = '0;
                  if (!bus.ld_last) begin
                     errOverflow_d = 1'b1;
                  end
               end
            end
         end

         HOLD: begin
            holdCnt_d = holdCnt_q + 8'd1;
            if (bus.reload) begin
               state_d       = LOAD;
               coreRst_d     = 1'b1;
               wordPtr_d     = '0;
               wordsLoaded_d = '0;
               errOverflow_d = 1'b0;
               holdCnt_d     = '0;
            end else if (holdCnt_q == HOLD_LAST) begin
               state_d   = RUN;
               coreRst_d = 1'b0;
            end
         end

         RUN: begin
            if (bus.reload) begin
               state_d       = LOAD;
               coreRst_d     = 1'b1;
               wordPtr_d     = '0;
               wordsLoaded_d = '0;
               errOverflow_d = 1'b0;
               holdCnt_d     = '0;
            end
         end

         default: begin
            state_d = LOAD;
         end
      endcase
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
//
// Purpose: directed self-checking bench for imem_boot_loader. dutA uses the
// full 2048-word RAM; dutB uses an 8-word RAM so the overflow path can be
// reached. Every write seen on dutA is matched against the expected image
// held in expImg.
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;

   logic clk_sys = 1'b0;
   logic rst     = 1'b1;

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   logic [31:0] expImg[$];
   int          wrIdx = 0;

   imem_boot_loader_if #(.ADDR_W(11)) busA ();
   imem_boot_loader_if #(.ADDR_W(3))  busB ();

   imem_boot_loader #(
      .IMEM_DEPTH(2048),
      .ADDR_W    (11),
      .RESET_HOLD(4)
   ) dutA (
      .clk_sys(clk_sys),
      .rst    (rst),
      .bus    (busA)
   );

   imem_boot_loader #(
      .IMEM_DEPTH(8),
      .ADDR_W    (3),
      .RESET_HOLD(4)
   ) dutB (
      .clk_sys(clk_sys),
      .rst    (rst),
      .bus    (busB)
   );

   // Free-running system clock, 10 time units per period.
   always #5 clk_sys = ~clk_sys;

   // One comparison: counts it, and reports tag/observed/expected on failure.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advance one clock and sample 1 unit after the edge. Any dutA write in
   // the new cycle must be the next word of the expected image.
   task automatic applyStimulus();
      @(posedge clk_sys);
      #1;
      if (busA.imem_we === 1'b1) begin
         if (wrIdx < expImg.size()) begin
            checkOutput("wr_addr", 32'(busA.imem_addr), 32'(wrIdx));
            checkOutput("wr_data", busA.imem_wdata, expImg[wrIdx]);
         end else begin
            checkOutput("extra_write", 32'(busA.imem_we), 32'd0);
         end
         wrIdx++;
      end
   endtask

   // Present one word to dutA (which must be in LOAD) and clock it in.
   task automatic sendWordA(input logic [31:0] data, input logic last);
      busA.ld_valid = 1'b1;
      busA.ld_data  = data;
      busA.ld_last  = last;
      applyStimulus();
      busA.ld_valid = 1'b0;
      busA.ld_last  = 1'b0;
   endtask

   // Pulse reload on dutA for one cycle.
   task automatic pulseReloadA();
      busA.reload = 1'b1;
      applyStimulus();
      busA.reload = 1'b0;
   endtask

   // Wait, with a cycle budget, for dutA to release the core.
   task automatic waitDoneA(input string tag);
      for (int k = 0; k < 20 && busA.done !== 1'b1; k++) begin
         applyStimulus();
      end
      checkOutput(tag, 32'(busA.done), 32'd1);
   endtask

   initial begin
      int sent;
      logic v;
      logic hs;

      busA.ld_valid = 1'b0;
      busA.ld_data  = '0;
      busA.ld_last  = 1'b0;
      busA.reload   = 1'b0;
      busB.ld_valid = 1'b0;
      busB.ld_data  = '0;
      busB.ld_last  = 1'b0;
      busB.reload   = 1'b0;

      // ---- Reset values ----
      applyStimulus();
      applyStimulus();
      checkOutput("rst_ld_ready", 32'(busA.ld_ready), 32'd0);
      checkOutput("rst_imem_we", 32'(busA.imem_we), 32'd0);
      checkOutput("rst_imem_addr", 32'(busA.imem_addr), 32'd0);
      checkOutput("rst_imem_wdata", busA.imem_wdata, 32'd0);
      checkOutput("rst_imem_sel", 32'(busA.imem_sel), 32'd1);
      checkOutput("rst_core_rst", 32'(busA.core_rst), 32'd1);
      checkOutput("rst_busy", 32'(busA.busy), 32'd1);
      checkOutput("rst_done", 32'(busA.done), 32'd0);
      checkOutput("rst_err", 32'(busA.err_overflow), 32'd0);
      checkOutput("rst_words", 32'(busA.words_loaded), 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("post_rst_ld_ready", 32'(busA.ld_ready), 32'd1);

      // ---- Basic 3-word load, core released 5 cycles after last handshake ----
      expImg = {32'h0000_0013, 32'h0010_0193, 32'h0000_006F};
      wrIdx  = 0;
      sendWordA(32'h0000_0013, 1'b0);
      sendWordA(32'h0010_0193, 1'b0);
      sendWordA(32'h0000_006F, 1'b1);
      checkOutput("basic_words", 32'(busA.words_loaded), 32'd3);
      checkOutput("basic_hold_sel", 32'(busA.imem_sel), 32'd0);
      checkOutput("basic_hold_ready", 32'(busA.ld_ready), 32'd0);
      checkOutput("basic_hold_we", 32'(busA.imem_we), 32'd1);
      checkOutput("basic_core_rst_e1", 32'(busA.core_rst), 32'd1);
      applyStimulus();
      checkOutput("basic_we_off", 32'(busA.imem_we), 32'd0);
      checkOutput("basic_core_rst_e2", 32'(busA.core_rst), 32'd1);
      applyStimulus();
      checkOutput("basic_core_rst_e3", 32'(busA.core_rst), 32'd1);
      applyStimulus();
      checkOutput("basic_core_rst_e4", 32'(busA.core_rst), 32'd1);
      checkOutput("basic_done_e4", 32'(busA.done), 32'd0);
      applyStimulus();
      checkOutput("basic_core_rst_e5", 32'(busA.core_rst), 32'd0);
      checkOutput("basic_done_e5", 32'(busA.done), 32'd1);
      checkOutput("basic_busy_e5", 32'(busA.busy), 32'd0);
      checkOutput("basic_write_count", 32'(wrIdx), 32'd3);

      // ---- RUN ignores ld_valid ----
      busA.ld_valid = 1'b1;
      busA.ld_data  = 32'hDEAD_BEEF;
      #1;
      checkOutput("run_ld_ready", 32'(busA.ld_ready), 32'd0);
      applyStimulus();
      checkOutput("run_no_write", 32'(busA.imem_we), 32'd0);
      busA.ld_valid = 1'b0;

      // ---- Overflow on the 8-word RAM: 10 words, none flagged last ----
      for (int i = 0; i < 8; i++) begin
         busB.ld_valid = 1'b1;
         busB.ld_data  = 32'hB000_0000 + 32'(i);
         busB.ld_last  = 1'b0;
         applyStimulus();
         checkOutput("ovf_we", 32'(busB.imem_we), 32'd1);
         checkOutput("ovf_addr", 32'(busB.imem_addr), 32'(i));
         checkOutput("ovf_data", busB.imem_wdata, 32'hB000_0000 + 32'(i));
      end
      checkOutput("ovf_ready", 32'(busB.ld_ready), 32'd0);
      checkOutput("ovf_err", 32'(busB.err_overflow), 32'd1);
      checkOutput("ovf_words", 32'(busB.words_loaded), 32'd8);
      checkOutput("ovf_sel", 32'(busB.imem_sel), 32'd0);
      busB.ld_data = 32'hB000_0008;
      applyStimulus();
      checkOutput("ovf_no_9th_write", 32'(busB.imem_we), 32'd0);
      checkOutput("ovf_core_rst_e2", 32'(busB.core_rst), 32'd1);
      busB.ld_data = 32'hB000_0009;
      applyStimulus();
      applyStimulus();
      checkOutput("ovf_core_rst_e4", 32'(busB.core_rst), 32'd1);
      applyStimulus();
      checkOutput("ovf_core_rst_e5", 32'(busB.core_rst), 32'd0);
      checkOutput("ovf_done", 32'(busB.done), 32'd1);
      checkOutput("ovf_err_sticky", 32'(busB.err_overflow), 32'd1);
      checkOutput("ovf_words_sat", 32'(busB.words_loaded), 32'd8);
      busB.ld_valid = 1'b0;

      // ---- Reload from RUN, then a 2-word image; reload in 2nd HOLD cycle ----
      pulseReloadA();
      checkOutput("rld_core_rst", 32'(busA.core_rst), 32'd1);
      checkOutput("rld_words", 32'(busA.words_loaded), 32'd0);
      checkOutput("rld_err", 32'(busA.err_overflow), 32'd0);
      checkOutput("rld_ready", 32'(busA.ld_ready), 32'd1);
      expImg = {32'h1111_0001, 32'h1111_0002};
      wrIdx  = 0;
      sendWordA(32'h1111_0001, 1'b0);
      sendWordA(32'h1111_0002, 1'b1);
      checkOutput("rld_write_count", 32'(wrIdx), 32'd2);
      applyStimulus();
      checkOutput("hold_rld_core_rst_a", 32'(busA.core_rst), 32'd1);
      pulseReloadA();
      checkOutput("hold_rld_core_rst_b", 32'(busA.core_rst), 32'd1);
      checkOutput("hold_rld_sel", 32'(busA.imem_sel), 32'd1);
      checkOutput("hold_rld_ready", 32'(busA.ld_ready), 32'd1);
      checkOutput("hold_rld_words", 32'(busA.words_loaded), 32'd0);
      applyStimulus();
      applyStimulus();
      applyStimulus();
      checkOutput("hold_rld_core_rst_c", 32'(busA.core_rst), 32'd1);

      // ---- Reload in LOAD coincident with a handshake is ignored ----
      expImg = {32'h2222_0000, 32'h2222_0001, 32'h2222_0002};
      wrIdx  = 0;
      sendWordA(32'h2222_0000, 1'b0);
      busA.reload = 1'b1;
      sendWordA(32'h2222_0001, 1'b0);
      busA.reload = 1'b0;
      checkOutput("load_rld_addr", 32'(busA.imem_addr), 32'd1);
      checkOutput("load_rld_words", 32'(busA.words_loaded), 32'd2);
      sendWordA(32'h2222_0002, 1'b1);
      checkOutput("load_rld_last_addr", 32'(busA.imem_addr), 32'd2);
      waitDoneA("load_rld_done");
      checkOutput("load_rld_write_count", 32'(wrIdx), 32'd3);

      // ---- Backpressure: 16 words with ld_valid toggled randomly ----
      pulseReloadA();
      expImg.delete();
      for (int i = 0; i < 16; i++) begin
         expImg.push_back(32'hC0DE_0000 + 32'(i * 7));
      end
      wrIdx = 0;
      sent  = 0;
      for (int k = 0; k < 400 && sent < 16; k++) begin
         v = 1'($urandom_range(0, 1));
         busA.ld_valid = v;
         busA.ld_data  = expImg[sent];
         busA.ld_last  = (sent == 15);
         hs = v && busA.ld_ready;
         applyStimulus();
         if (hs) sent++;
      end
      busA.ld_valid = 1'b0;
      busA.ld_last  = 1'b0;
      checkOutput("bp_sent", 32'(sent), 32'd16);
      waitDoneA("bp_done");
      checkOutput("bp_write_count", 32'(wrIdx), 32'd16);
      checkOutput("bp_words", 32'(busA.words_loaded), 32'd16);

      // ---- Async reset between edges after 5th handshake of 10 ----
      pulseReloadA();
      expImg.delete();
      for (int i = 0; i < 10; i++) begin
         expImg.push_back(32'h3333_0000 + 32'(i));
      end
      wrIdx = 0;
      busA.ld_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         busA.ld_data = expImg[i];
         applyStimulus();
      end
      checkOutput("arst_pre_we", 32'(busA.imem_we), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("arst_we", 32'(busA.imem_we), 32'd0);
      checkOutput("arst_core_rst", 32'(busA.core_rst), 32'd1);
      checkOutput("arst_ready", 32'(busA.ld_ready), 32'd0);
      checkOutput("arst_words", 32'(busA.words_loaded), 32'd0);
      busA.ld_valid = 1'b0;
      applyStimulus();
      rst = 1'b0;
      expImg = {32'h4444_0000, 32'h4444_0001};
      wrIdx  = 0;
      sendWordA(32'h4444_0000, 1'b0);
      sendWordA(32'h4444_0001, 1'b1);
      checkOutput("arst_new_words", 32'(busA.words_loaded), 32'd2);
      waitDoneA("arst_new_done");
      checkOutput("arst_new_write_count", 32'(wrIdx), 32'd2);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
